switch_conditioner: RTL and testbench

//   Conditions the raw ML605 GPIO DIP switches before they reach the LED counter's mode inputs (up/down, pause/run, left/right, slow/fast).
//   Per channel: multi-flop synchronizer into sys_clk, then a counter-based debouncer.

---
 rtl/switch_conditioner_if.sv | 33 +++
 rtl/switch_conditioner.sv | 134 +++++++++++++
 tb/tb_switch_conditioner.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_conditioner_if.sv
// switch_conditioner_if: groups the raw switch input and the conditioned outputs of
// switch_conditioner into one bundle.
//   sw_raw      asynchronous switch levels from the pins
//   sw_db       debounced, synchronized level
//   sw_rise     one-cycle pulse when sw_db goes 0->1
//   sw_fall     one-cycle pulse when sw_db goes 1->0
//   sw_settling high while a channel is timing a pending change
// The slave modport is the conditioner's view. The master modport is the consumer or driver view.
interface switch_conditioner_if #(
    parameter int unsigned NUM_SW = 4
);
    logic [NUM_SW-1:0] sw_raw;
    logic [NUM_SW-1:0] sw_db;
    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] sw_fall;
    logic [NUM_SW-1:0] sw_settling;

    modport master (
        output sw_raw,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  sw_settling
    );

    modport slave (
        input  sw_raw,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output sw_settling
    );
endinterface

// File: rtl/switch_conditioner.sv
// switch_conditioner: conditions raw DIP switch levels for use in the sys_clk domain.
// Each channel has a SYNC_STAGES-deep synchronizer, followed by a counter-based debouncer.
// The debouncer accepts a new level only after it has been seen on DEBOUNCE_CYCLES
// consecutive edges. Each accepted change produces a registered one-cycle rise or fall strobe.
//   sys_clk  in   system clock
//   reset    in   synchronous active-high reset
//   sw       slave modport of switch_conditioner_if, which carries the following signals:
//            sw_raw       asynchronous switch levels
//            sw_db        debounced level
//            sw_rise      rise strobe
//            sw_fall      fall strobe
//            sw_settling  pending-change flag
module switch_conditioner #(
    parameter int unsigned NUM_SW          = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    switch_conditioner_if.slave  sw
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {StStable, StSettling} state_e;

    logic [NUM_SW-1:0] sync_q [SYNC_STAGES];
    logic [NUM_SW-1:0] syn;

    state_e            state_q [NUM_SW];
    state_e            state_d [NUM_SW];
    logic [CNT_W-1:0]  cnt_q   [NUM_SW];
    logic [CNT_W-1:0]  cnt_d   [NUM_SW];
    logic [NUM_SW-1:0] db_q, db_d;
    logic [NUM_SW-1:0] rise_q, rise_d;
    logic [NUM_SW-1:0] fall_q, fall_d;
    logic [NUM_SW-1:0] settling;

    // Synchronizer chain. Only stage 0 ever samples sw_raw.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= sw.sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    // Per-channel debounce FSMs. The channels are fully independent of each other.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            case (state_q[i])
                StStable: begin
                    cnt_d[i] = '0;
                    if (syn[i] != db_q[i]) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // With a single required cycle, the first mismatch is already stable enough.
                            db_d[i]   = syn[i];
                            rise_d[i] = syn[i];
                            fall_d[i] = ~syn[i];
                        end else begin
                            state_d[i] = StSettling;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                StSettling: begin
                    if (syn[i] == db_q[i]) begin
                        // The level returned to its old value before timing out, so drop the change silently.
                        state_d[i] = StStable;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        db_d[i]    = syn[i];
                        rise_d[i]  = syn[i];
                        fall_d[i]  = ~syn[i];
                        state_d[i] = StStable;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = StStable;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SW; i++) begin
                state_q[i] <= StStable;
                cnt_q[i]   <= '0;
            end
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SW; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    always_comb begin
        settling = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            settling[i] = (state_q[i] == StSettling);
        end
    end

    assign sw.sw_db       = db_q;
    assign sw.sw_rise     = rise_q;
    assign sw.sw_fall     = fall_q;
    assign sw.sw_settling = settling;

endmodule

// File: tb/tb_switch_conditioner.sv
// Testbench for switch_conditioner with NUM_SW=4, SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
// An input-history model pushes the expected outputs for each edge onto a queue.
// Each test task pops those expected values and compares them with the DUT after the edge.
module tb_switch_conditioner;

    localparam int unsigned NSW = 4;
    localparam int unsigned NSY = 2;
    localparam int unsigned NDB = 4;

    typedef struct packed {
        logic [NSW-1:0] db;
        logic [NSW-1:0] rise;
        logic [NSW-1:0] fall;
        logic [NSW-1:0] settle;
    } exp_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;

    switch_conditioner_if #(.NUM_SW(NSW)) sw_if ();

    switch_conditioner #(
        .NUM_SW          (NSW),
        .SYNC_STAGES     (NSY),
        .DEBOUNCE_CYCLES (NDB)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .sw      (sw_if)
    );

    always #5 sys_clk = ~sys_clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    // Model state: a delay line for the raw inputs, the last NDB synchronized samples, and the level.
    logic [NSW-1:0] m_pipe [NSY];
    logic [NSW-1:0] m_hist [NDB];
    logic [NSW-1:0] m_db = '0;

    // Drives one cycle of stimulus, advances the model across the edge, and queues the expected outputs.
    task automatic drive_cycle(input logic [NSW-1:0] raw, input logic rst);
        exp_t           e;
        logic [NSW-1:0] new_syn, all_diff, old_db;
        @(negedge sys_clk);
        sw_if.sw_raw = raw;
        reset        = rst;
        @(posedge sys_clk);
        #1;
        if (rst) begin
            for (int s = 0; s < NSY; s++) m_pipe[s] = '0;
            for (int j = 0; j < NDB; j++) m_hist[j] = '0;
            m_db = '0;
            e    = '0;
        end else begin
            new_syn = m_pipe[NSY-1];
            for (int s = NSY - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
            m_pipe[0] = raw;
            for (int j = NDB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = new_syn;
            // A bit flips once each of the last NDB samples disagrees with the current level.
            all_diff = '1;
            for (int j = 0; j < NDB; j++) all_diff &= (m_hist[j] ^ m_db);
            old_db   = m_db;
            m_db     = m_db ^ all_diff;
            e.db     = m_db;
            e.rise   = m_db & ~old_db;
            e.fall   = ~m_db & old_db;
            e.settle = new_syn ^ m_db;
        end
        sb.push_back(e);
    endtask

    function automatic exp_t observe();
        exp_t g;
        g.db     = sw_if.sw_db;
        g.rise   = sw_if.sw_rise;
        g.fall   = sw_if.sw_fall;
        g.settle = sw_if.sw_settling;
        return g;
    endfunction

    task automatic test_reset();
        exp_t e, g;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(4'hF, 1'b1);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: got %h want 0000", c, g);
            end
        end
        // The first post-reset edge is edge 0. The new level must land on edge 5.
        for (int c = 0; c < 9; c++) begin
            drive_cycle(4'hF, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset_release c%0d: got %h want %h", c, g, e);
            end
            n_checks++;
            if (g.rise !== ((c == 5) ? 4'hF : 4'h0)) begin
                n_fail++;
                $display("FAIL reset_rise_time c%0d: got %h want %h", c, g.rise, (c == 5) ? 4'hF : 4'h0);
            end
        end
    endtask

    task automatic test_clean_edge();
        exp_t e, g;
        // Bring every channel low first. The model supplies the expected falls.
        for (int c = 0; c < 10; c++) begin
            drive_cycle(4'h0, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL clean_prep c%0d: got %h want %h", c, g, e);
            end
        end
        for (int c = 0; c < 9; c++) begin
            drive_cycle(4'h1, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL clean_edge c%0d: got %h want %h", c, g, e);
            end
            n_checks++;
            if (g.rise[0] !== (c == 5) || g.settle[0] !== (c >= 2 && c <= 4)
                || g.db[0] !== (c >= 5)) begin
                n_fail++;
                $display("FAIL clean_timing c%0d: got r%b s%b d%b want r%b s%b d%b", c,
                         g.rise[0], g.settle[0], g.db[0], c == 5, c >= 2 && c <= 4, c >= 5);
            end
        end
    endtask

    task automatic test_bounce();
        exp_t e, g;
        logic [NSW-1:0] pat [5] = '{4'h3, 4'h1, 4'h3, 4'h1, 4'h3};
        int rises = 0;
        int rise_at = -1;
        for (int c = 0; c < 14; c++) begin
            drive_cycle((c < 5) ? pat[c] : 4'h3, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL bounce c%0d: got %h want %h", c, g, e);
            end
            if (g.rise[1]) begin
                rises++;
                rise_at = c;
            end
        end
        // The final 0->1 sample happens at edge 4, so exactly one rise must follow 5 edges later.
        n_checks++;
        if (rises != 1 || rise_at != 9) begin
            n_fail++;
            $display("FAIL bounce_single_rise: got %0d rises at %0d want 1 at 9", rises, rise_at);
        end
    endtask

    task automatic test_glitch();
        exp_t e, g;
        int bad = 0;
        for (int c = 0; c < 11; c++) begin
            drive_cycle((c < 3) ? 4'h7 : 4'h3, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL glitch c%0d: got %h want %h", c, g, e);
            end
            if (g.db[2] || g.rise[2] || g.fall[2]) bad++;
        end
        n_checks++;
        if (bad != 0 || sw_if.sw_settling[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_quiet: got %0d bad cycles settle %b want 0 and 0", bad, sw_if.sw_settling[2]);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e, g;
        int both_fall = 0;
        int any_rise = 0;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(4'hF, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simul_up c%0d: got %h want %h", c, g, e);
            end
        end
        for (int c = 0; c < 10; c++) begin
            drive_cycle(4'h3, 1'b0);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL simul_down c%0d: got %h want %h", c, g, e);
            end
            if (g.fall[3:2] == 2'b11) both_fall++;
            if (g.rise != 4'h0) any_rise++;
        end
        n_checks++;
        if (both_fall != 1 || any_rise != 0) begin
            n_fail++;
            $display("FAIL simul_fall: got %0d joint falls %0d rises want 1 and 0", both_fall, any_rise);
        end
    endtask

    task automatic test_reset_mid_settle();
        exp_t e, g;
        int strobes = 0;
        // Channel 0 drops at edge 0 and enters settling at edge 2. Reset is asserted on edge 4.
        for (int c = 0; c < 12; c++) begin
            drive_cycle(4'h0, c == 4);
            e = sb.pop_front();
            g = observe();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL mid_settle c%0d: got %h want %h", c, g, e);
            end
            if (c >= 4 && (g.rise != 4'h0 || g.fall != 4'h0)) strobes++;
            if (c == 4) begin
                n_checks++;
                if (g !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL mid_settle_reset: got %h want 0000", g);
                end
            end
        end
        n_checks++;
        if (strobes != 0) begin
            n_fail++;
            $display("FAIL mid_settle_strobe: got %0d strobes want 0", strobes);
        end
    endtask

    initial begin
        sw_if.sw_raw = '0;
        for (int s = 0; s < NSY; s++) m_pipe[s] = '0;
        for (int j = 0; j < NDB; j++) m_hist[j] = '0;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_glitch();
        test_simultaneous();
        test_reset_mid_settle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
